// File: rtl/inst_decode.sv
// inst_decode: ID stage with 32-entry register file, R/I-subset decode and registered ID/EX outputs
module inst_decode #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instruction_in,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [REG_AW-1:0] dest_addr,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic              reg_we,
  output logic              valid_out,
  output logic              illegal
);
  logic [DATA_W-1:0] rf [2**REG_AW];
  logic [5:0] op, funct;
  logic [REG_AW-1:0] rs, rt, rd, d_dest;
  logic [3:0] r_op, d_alu;
  logic r_ok, is_r, is_andi, is_addi, dec_ok, wb_hit;
  logic [DATA_W-1:0] rs_rd, rt_rd, d_imm;
  assign op      = instruction_in[31:26];
  assign funct   = instruction_in[5:0];
  assign rs      = instruction_in[21 +: REG_AW];
  assign rt      = instruction_in[16 +: REG_AW];
  assign rd      = instruction_in[11 +: REG_AW];
  assign wb_hit  = wb_we && wb_waddr != '0;
  // r0 is never written, so the array read alone already returns 0 for it
  assign rs_rd   = (BYPASS_EN != 0 && wb_hit && wb_waddr == rs) ? wb_wdata : rf[rs];
  assign rt_rd   = (BYPASS_EN != 0 && wb_hit && wb_waddr == rt) ? wb_wdata : rf[rt];
  always_comb begin
    r_ok = 1'b1;
    case (funct)
      6'b100100: r_op = 4'd0;
      6'b100101: r_op = 4'd1;
      6'b100110: r_op = 4'd2;
      6'b100111: r_op = 4'd3;
      6'b100000: r_op = 4'd4;
      6'b100001: r_op = 4'd5;
      6'b100010: r_op = 4'd6;
      6'b100011: r_op = 4'd7;
      6'b101010: r_op = 4'd8;
      default: begin
        r_op = 4'd0;
        r_ok = 1'b0;
      end
    endcase
  end
  assign is_r    = op == 6'b000000;
  assign is_andi = op == 6'b001100;
  assign is_addi = op == 6'b001000;
  assign dec_ok  = (is_r && r_ok) || is_andi || is_addi;
  assign d_dest  = !dec_ok ? '0 : is_r ? rd : rt;
  assign d_alu   = is_r ? r_op : is_addi ? 4'd4 : 4'd0;
  assign d_imm   = is_andi ? {{(DATA_W-16){1'b0}}, instruction_in[15:0]}
                           : {{(DATA_W-16){instruction_in[15]}}, instruction_in[15:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out      <= '0;
      rs_data     <= '0;
      rt_data     <= '0;
      imm_ext     <= '0;
      dest_addr   <= '0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      reg_we      <= 1'b0;
      valid_out   <= 1'b0;
      illegal     <= 1'b0;
    end else if (!stall) begin
      pc_out      <= pc_in;
      rs_data     <= rs_rd;
      rt_data     <= rt_rd;
      imm_ext     <= d_imm;
      dest_addr   <= d_dest;
      alu_op      <= d_alu;
      alu_src_imm <= is_andi || is_addi;
      reg_we      <= dec_ok && d_dest != '0;
      valid_out   <= 1'b1;
      illegal     <= !dec_ok && instruction_in != '0;
    end
  end
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: random + directed check of inst_decode (bypass on and off) against a behavioural model
module tb_inst_decode;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, flush, wb_we;
  logic [31:0] pc_in, instruction_in, wb_wdata;
  logic [4:0] wb_waddr;
  logic [31:0] pc1, rs1, rt1, imm1, pc0, rs0, rt0, imm0;
  logic [4:0] d1, d0;
  logic [3:0] a1, a0;
  logic s1, s0, w1, w0, v1, v0, i1, i0;
  inst_decode #(.BYPASS_EN(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_in(pc_in),
    .instruction_in(instruction_in), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .pc_out(pc1), .rs_data(rs1), .rt_data(rt1), .imm_ext(imm1), .dest_addr(d1), .alu_op(a1),
    .alu_src_imm(s1), .reg_we(w1), .valid_out(v1), .illegal(i1));
  inst_decode #(.BYPASS_EN(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_in(pc_in),
    .instruction_in(instruction_in), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .pc_out(pc0), .rs_data(rs0), .rt_data(rt0), .imm_ext(imm0), .dest_addr(d0), .alu_op(a0),
    .alu_src_imm(s0), .reg_we(w0), .valid_out(v0), .illegal(i0));
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  localparam int M_RST = 0, M_FL = 1, M_MIN = 2, M_R = 3, M_I = 4;
  logic [31:0] mreg [32];
  logic [5:0] fl [9] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2a};
  logic [31:0] e_pc, e_imm, e_rs1, e_rs0, e_rt1, e_rt0;
  logic [4:0] e_dest;
  logic [3:0] e_alu;
  logic e_src, e_we, e_v, e_ill;
  int mode;
  logic [31:0] pcc = 32'h100;
  function automatic int alu_of(input logic [5:0] f);
    for (int j = 0; j < 9; j++) if (fl[j] == f) return j;
    return -1;
  endfunction
  function automatic logic [31:0] rd_reg(input logic [4:0] idx, input bit byp);
    if (idx == 0) return 0;
    if (byp && wb_we && wb_waddr == idx) return wb_wdata;
    return mreg[idx];
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] f);
    return {6'd0, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction
  task automatic model_decode(input logic [31:0] ins);
    int k;
    k = alu_of(ins[5:0]);
    e_pc = pc_in;
    e_rs1 = rd_reg(ins[25:21], 1'b1);
    e_rs0 = rd_reg(ins[25:21], 1'b0);
    e_rt1 = rd_reg(ins[20:16], 1'b1);
    e_rt0 = rd_reg(ins[20:16], 1'b0);
    e_v = 1'b1;
    e_ill = 1'b0;
    e_we = 1'b0;
    if (ins == 0) mode = M_MIN;
    else if (ins[31:26] == 0 && k >= 0) begin
      mode = M_R;
      e_alu = 4'(k);
      e_dest = ins[15:11];
      e_src = 1'b0;
      e_we = ins[15:11] != 0;
    end else if (ins[31:26] == 6'd8 || ins[31:26] == 6'd12) begin
      mode = M_I;
      e_alu = ins[31:26] == 6'd8 ? 4'd4 : 4'd0;
      e_dest = ins[20:16];
      e_src = 1'b1;
      e_we = ins[20:16] != 0;
      e_imm = ins[31:26] == 6'd8 ? 32'($signed(ins[15:0])) : 32'(ins[15:0]);
    end else begin
      mode = M_MIN;
      e_ill = 1'b1;
    end
  endtask
  task automatic compare();
    chk("valid", 32'(v1), 32'(e_v));
    chk("valid_nb", 32'(v0), 32'(e_v));
    chk("reg_we", 32'(w1), 32'(e_we));
    chk("illegal", 32'(i1), 32'(e_ill));
    if (mode == M_RST || mode == M_FL) chk("alu_clr", 32'(a1), 0);
    if (mode == M_RST) begin
      chk("rst_pc", pc1, 0);
      chk("rst_rs", rs1, 0);
      chk("rst_rt", rt1, 0);
      chk("rst_imm", imm1, 0);
      chk("rst_dest", 32'(d1), 0);
      chk("rst_src", 32'(s1), 0);
    end
    if (mode >= M_MIN) chk("pc", pc1, e_pc);
    if (mode >= M_R) begin
      chk("rs_byp", rs1, e_rs1);
      chk("rs_nobyp", rs0, e_rs0);
      chk("rt_byp", rt1, e_rt1);
      chk("rt_nobyp", rt0, e_rt0);
      chk("dest", 32'(d1), 32'(e_dest));
      chk("alu_op", 32'(a1), 32'(e_alu));
      chk("alu_src", 32'(s1), 32'(e_src));
    end
    if (mode == M_I) chk("imm", imm1, e_imm);
  endtask
  task automatic cyc(input logic r, s, f, input logic [31:0] ins, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    rst = r; stall = s; flush = f; instruction_in = ins; pc_in = pcc;
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    if (r) begin
      mode = M_RST;
      e_v = 0; e_we = 0; e_ill = 0; e_alu = 0;
      for (int j = 0; j < 32; j++) mreg[j] = 0;
    end else begin
      if (f) begin
        mode = M_FL;
        e_v = 0; e_we = 0; e_ill = 0; e_alu = 0;
      end else if (!s) model_decode(ins);
      if (we && wa != 0) mreg[wa] = wd;
    end
    pcc += 4;
    @(posedge clk);
    #1;
    compare();
  endtask
  function automatic logic [31:0] rand_ins();
    int sel;
    logic [4:0] a, b, c;
    sel = $urandom_range(0, 9);
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case (sel)
      0, 1, 2, 3, 4: return rtype(a, b, c, fl[$urandom_range(0, 8)]);
      5: return itype(6'd12, a, b, 16'($urandom));
      6: return itype(6'd8, a, b, 16'($urandom));
      7: return $urandom;
      8: return 0;
      default: return rtype(a, b, c, 6'($urandom));
    endcase
  endfunction
  initial begin
    rst = 1; stall = 0; flush = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    pc_in = 0; instruction_in = 0;
    cyc(1, 1, 1, rtype(1, 2, 3, 6'h24), 1, 5'd1, 32'hDEADBEEF);
    cyc(1, 0, 0, rtype(1, 2, 3, 6'h24), 1, 5'd2, 32'h12345678);
    for (int i = 1; i < 32; i++) begin
      cyc(0, 0, 0, rtype(5'(i), 5'(32 - i), 5'd3, 6'h25), 0, 5'd0, 0);
      chk("post_rst_rs", rs1, 0);
      chk("post_rst_rt", rt1, 0);
    end
    cyc(0, 0, 0, 0, 1, 5'd1, 5);
    cyc(0, 0, 0, 0, 1, 5'd2, 3);
    cyc(0, 0, 0, 32'h00221824, 0, 5'd0, 0);
    chk("and_rs", rs1, 5);
    chk("and_rt", rt1, 3);
    chk("and_dest", 32'(d1), 3);
    chk("and_alu", 32'(a1), 0);
    chk("and_we", 32'(w1), 1);
    cyc(0, 0, 0, 32'h2022FFFF, 0, 5'd0, 0);
    chk("addi_imm", imm1, 32'hFFFFFFFF);
    cyc(0, 0, 0, 32'h3022FFFF, 0, 5'd0, 0);
    chk("andi_imm", imm1, 32'h0000FFFF);
    chk("andi_src", 32'(s1), 1);
    cyc(0, 0, 0, 32'h00221824, 1, 5'd1, 32'hA);
    chk("bypass_on", rs1, 32'hA);
    chk("bypass_off", rs0, 5);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, rtype(5'(i + 3), 5'd1, 5'd7, 6'h20), 1, 5'(i + 4), 32'(i + 100));
      chk("stall_pc", pc1, e_pc);
    end
    cyc(0, 0, 0, rtype(5'd4, 5'd5, 5'd6, 6'h22), 0, 5'd0, 0);
    cyc(0, 1, 1, rtype(5'd4, 5'd5, 5'd6, 6'h22), 0, 5'd0, 0);
    chk("flush_stall_valid", 32'(v1), 0);
    cyc(0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
    cyc(0, 0, 0, rtype(5'd0, 5'd0, 5'd4, 6'h25), 0, 5'd0, 0);
    chk("r0_rs", rs1, 0);
    cyc(0, 0, 0, 32'hFC000000, 0, 5'd0, 0);
    chk("illegal_fc", 32'(i1), 1);
    chk("illegal_we", 32'(w1), 0);
    for (int n = 0; n < 800; n++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
          rand_ins(), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
